// File: rtl/uart_transceiver_if.sv
// Bus bundle for uart_transceiver: TX byte handshake, serial lines and RX result/status.
// slave is the transceiver side; master is the user / line side.
interface uart_transceiver_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 TX;
  logic                 RX;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  RX,
    output tx_ready,
    output TX,
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err
  );

  modport master (
    output tx_data,
    output tx_valid,
    output RX,
    input  tx_ready,
    input  TX,
    input  rx_data,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err
  );

endinterface

// File: rtl/uart_transceiver.sv
// Parametrised UART transmitter and receiver on one clock: configurable width, parity, stop bits.
// TX has a valid/ready handshake; RX reports parity and framing errors with a one-cycle valid.
module uart_transceiver #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input logic                clk,
  input logic                rst,
  uart_transceiver_if.slave  bus
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned CntW = $clog2(CPB);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntMax   = CntW'(CPB - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CPB / 2 - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {StTxIdle, StTxStart, StTxData, StTxParity, StTxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StTxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // The line is registered: each transition loads the level of the bit being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    unique case (tx_state_q)
      StTxIdle: begin
        tx_line_d = 1'b1;
        if (bus.tx_valid) begin
          tx_state_d = StTxStart;
          tx_shift_d = bus.tx_data;
          tx_par_d   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
        end
      end
      StTxStart: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StTxData;
          tx_line_d  = tx_shift_q[0];
        end
      end
      StTxData: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DataLast) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_state_d = StTxParity;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = StTxStop;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      StTxParity: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StTxStop;
          tx_line_d  = 1'b1;
        end
      end
      StTxStop: begin
        tx_cnt_d  = tx_cnt_q + 1'b1;
        tx_line_d = 1'b1;
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d = '0;
          if (tx_bit_q == StopLast) begin
            tx_state_d = StTxIdle;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = StTxIdle;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  assign bus.TX       = tx_line_q;
  assign bus.tx_ready = (tx_state_q == StTxIdle);

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    StRxIdle, StRxStart, StRxData, StRxParity, StRxStop, StRxBreak
  } rx_state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_facc_q, rx_facc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_par_exp;
  logic                 rx_ferr_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_state_q <= StRxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.RX};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_facc_q  <= rx_facc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_s        = sync_q[1];
  assign rx_par_exp  = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
  assign rx_ferr_now = rx_facc_q | ~rx_s;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_facc_d  = rx_facc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    unique case (rx_state_q)
      StRxIdle: begin
        if (!rx_s) begin
          rx_state_d = StRxStart;
          rx_cnt_d   = '0;
        end
      end
      // Half-bit qualification rejects short glitches and aligns later samples to bit centres.
      StRxStart: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_facc_d  = 1'b0;
          rx_state_d = rx_s ? StRxIdle : StRxData;
        end
      end
      StRxData: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? StRxParity : StRxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      StRxParity: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s;
          rx_state_d = StRxStop;
        end
      end
      StRxStop: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d  = '0;
          rx_facc_d = rx_ferr_now;
          if (rx_bit_q == StopLast) begin
            rx_data_d  = rx_shift_q;
            rx_perr_d  = (PARITY != 0) && (rx_par_q != rx_par_exp);
            rx_ferr_d  = rx_ferr_now;
            rx_valid_d = 1'b1;
            rx_state_d = rx_ferr_now ? StRxBreak : StRxIdle;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      // A held-low line after a framing error must not look like a new start bit.
      StRxBreak: begin
        if (rx_s) begin
          rx_state_d = StRxIdle;
        end
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench: an 8N1 instance and an 8E2 instance at 16 clocks per bit,
// with a received-frame scoreboard per instance.
module tb_uart_transceiver;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          CPB      = 16;
  localparam int          LIMIT    = 5000;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       flip;
    logic       s1;
    logic       s2;
    logic [7:0] exp_d;
    logic       exp_p;
    logic       exp_f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   loop_n = 1'b0;
  bit   loop_e = 1'b0;
  logic rx_drv_n = 1'b1;
  logic rx_drv_e = 1'b1;

  int total = 0;
  int bad = 0;
  int pulses_n = 0;
  int pulses_e = 0;
  exp_t q_n[$];
  exp_t q_e[$];
  exp_t got_n, got_e;

  always #5 clk = ~clk;

  uart_transceiver_if #(.DATA_BITS(8)) bn ();
  uart_transceiver_if #(.DATA_BITS(8)) be ();

  assign bn.RX = loop_n ? bn.TX : rx_drv_n;
  assign be.RX = loop_e ? be.TX : rx_drv_e;

  uart_transceiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_n (
    .clk(clk),
    .rst(rst),
    .bus(bn)
  );

  uart_transceiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) u_e (
    .clk(clk),
    .rst(rst),
    .bus(be)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bn.rx_valid === 1'b1) begin
      pulses_n++;
      if (q_n.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_n spurious rx_valid: got data %0h want no pulse", bn.rx_data);
      end else begin
        got_n = q_n.pop_front();
        check("rx_n data", 32'(bn.rx_data), 32'(got_n.d));
        check("rx_n parity_err", 32'(bn.rx_parity_err), 32'(got_n.p));
        check("rx_n frame_err", 32'(bn.rx_frame_err), 32'(got_n.f));
      end
    end
    if (be.rx_valid === 1'b1) begin
      pulses_e++;
      if (q_e.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_e spurious rx_valid: got data %0h want no pulse", be.rx_data);
      end else begin
        got_e = q_e.pop_front();
        check("rx_e data", 32'(be.rx_data), 32'(got_e.d));
        check("rx_e parity_err", 32'(be.rx_parity_err), 32'(got_e.p));
        check("rx_e frame_err", 32'(be.rx_frame_err), 32'(got_e.f));
      end
    end
  end

  // Returns just after the accepting clock edge.
  task automatic send_n(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!bn.tx_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("send_n ready timeout", 32'(t < LIMIT), 32'd1);
    bn.tx_data  = d;
    bn.tx_valid = 1'b1;
    @(posedge clk);
    #1 bn.tx_valid = 1'b0;
  endtask

  task automatic send_e(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!be.tx_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("send_e ready timeout", 32'(t < LIMIT), 32'd1);
    be.tx_data  = d;
    be.tx_valid = 1'b1;
    @(posedge clk);
    #1 be.tx_valid = 1'b0;
  endtask

  // Leaves the line at the last stop-bit level.
  task automatic drive_frame(input bit sel_e, input logic [7:0] d, input bit flip,
                             input bit s1, input bit s2);
    logic [11:0] fr;
    int n;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
    if (sel_e) begin
      fr[9]  = (^d) ^ flip;
      fr[10] = s1;
      fr[11] = s2;
      n = 12;
    end else begin
      fr[9] = s1;
      n = 10;
    end
    for (int b = 0; b < n; b++) begin
      if (sel_e) rx_drv_e = fr[b];
      else rx_drv_n = fr[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle_line(input bit sel_e, input int nbits);
    if (sel_e) rx_drv_e = 1'b1;
    else rx_drv_n = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q_n.size() != 0 || q_e.size() != 0) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard drain", 32'(q_n.size() + q_e.size()), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fb;
    int low;
    int p0;
    logic [7:0] d;

    vecs[0] = '{8'h60, 1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};

    bn.tx_data = '0; bn.tx_valid = 1'b0;
    be.tx_data = '0; be.tx_valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst TX", 32'(bn.TX), 32'd1);
    check("rst tx_ready", 32'(bn.tx_ready), 32'd1);
    check("rst rx_data", 32'(bn.rx_data), 32'd0);
    check("rst rx_valid", 32'(bn.rx_valid), 32'd0);
    check("rst perr", 32'(bn.rx_parity_err), 32'd0);
    check("rst ferr", 32'(bn.rx_frame_err), 32'd0);
    check("rst e TX", 32'(be.TX), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x60 serialised 8N1; tx_ready low for exactly 10 bit times.
    d = 8'h60;
    fb = {1'b1, d, 1'b0};
    low = 0;
    send_n(d);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (!bn.tx_ready) low++;
      if (i % CPB == CPB / 2) check($sformatf("tx bit %0d", i / CPB), 32'(bn.TX), 32'(fb[i / CPB]));
    end
    @(negedge clk);
    check("tx_ready low clocks", 32'(low), 32'(10 * CPB));
    check("tx_ready back", 32'(bn.tx_ready), 32'd1);

    // Ten 0x60 bytes looped back, back-to-back.
    loop_n = 1'b1;
    p0 = pulses_n;
    for (int k = 0; k < 10; k++) begin
      q_n.push_back('{8'h60, 1'b0, 1'b0});
      send_n(8'h60);
    end
    wait_drain();
    check("loopback pulses", 32'(pulses_n - p0), 32'd10);
    loop_n = 1'b0;
    idle_line(1'b0, 2);

    // Even parity loopback: parity bit of 0x60 is 0.
    loop_e = 1'b1;
    q_e.push_back('{8'h60, 1'b0, 1'b0});
    send_e(8'h60);
    for (int i = 0; i < 9 * CPB + CPB / 2; i++) @(negedge clk);
    check("tx parity bit", 32'(be.TX), 32'(^d));
    wait_drain();
    idle_line(1'b1, 3);
    loop_e = 1'b0;

    // Bench-driven 8E2 frames: parity flips and low stop bits.
    for (int v = 0; v < 6; v++) begin
      q_e.push_back('{vecs[v].exp_d, vecs[v].exp_p, vecs[v].exp_f});
      drive_frame(1'b1, vecs[v].d, vecs[v].flip, vecs[v].s1, vecs[v].s2);
      idle_line(1'b1, 2);
      wait_drain();
      check($sformatf("vec %0d hold data", v), 32'(be.rx_data), 32'(vecs[v].exp_d));
    end

    // Stop bit low then line held low: one pulse, no retrigger.
    p0 = pulses_n;
    q_n.push_back('{8'h55, 1'b0, 1'b1});
    drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    idle_line(1'b0, 3);
    wait_drain();
    check("break pulses", 32'(pulses_n - p0), 32'd1);
    check("break ferr hold", 32'(bn.rx_frame_err), 32'd1);

    // Short low glitch is a false start; a following frame is still received.
    p0 = pulses_n;
    rx_drv_n = 1'b0;
    repeat (4) @(negedge clk);
    idle_line(1'b0, 3);
    check("glitch pulses", 32'(pulses_n - p0), 32'd0);
    q_n.push_back('{8'hA5, 1'b0, 1'b0});
    drive_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    idle_line(1'b0, 2);
    wait_drain();
    check("post-glitch data", 32'(bn.rx_data), 32'hA5);
    check("post-glitch ferr", 32'(bn.rx_frame_err), 32'd0);

    // Reset in the middle of a looped TX/RX frame.
    loop_n = 1'b1;
    p0 = pulses_n;
    send_n(8'h33);
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst mid TX", 32'(bn.TX), 32'd1);
      check("rst mid tx_ready", 32'(bn.tx_ready), 32'd1);
    end
    check("rst mid rx_data", 32'(bn.rx_data), 32'd0);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("rst mid pulses", 32'(pulses_n - p0), 32'd0);
    q_n.push_back('{8'h9C, 1'b0, 1'b0});
    send_n(8'h9C);
    wait_drain();
    check("post-rst pulses", 32'(pulses_n - p0), 32'd1);
    repeat (2 * CPB) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
